// File: rtl/trn_tx_arb.sv
// trn_tx_arb: round-robin arbiter and multiplexer for the PCIe endpoint TRN tx interface.
//
// N requesters share one TRN tx port. A requester raises req_i[i]; the arbiter answers with a
// registered one-hot grant (my_trn_o). The grantee signals that it drives the bus with drv_ep_i[i].
// The bus owner changes only between TLPs, and every ownership change is preceded by exactly one
// cycle with no grant (turnaround).
//
// Parameters
//   N         number of requesters (2..8); requester 0 gets the first grant after reset
//   WDOG_CYC  cycles a grantee may hold a grant without raising drv_ep (watchdog build only)
//
// Ports
//   clk_i                    clock (pcie_clk domain)
//   rst_i                    synchronous, active-high reset
//   req_i[N]                 per-requester bus request
//   my_trn_o[N]              one-hot (or zero) registered grant
//   drv_ep_i[N]              per-requester "driving the bus" flag (only honoured for the grantee)
//   req_trn_td_i[N*64]       per-requester data, requester i at [64*i +: 64]
//   req_trn_trem_n_i[N*8]    per-requester remainder
//   req_trn_tsof_n_i[N]      per-requester start of frame
//   req_trn_teof_n_i[N]      per-requester end of frame
//   req_trn_tsrc_rdy_n_i[N]  per-requester source ready
//   req_trn_tdst_rdy_n_o[N]  destination ready back to requesters; 1 for every non-owner
//   req_trn_tbuf_av_o[N*4]   buffer-available broadcast to every requester
//   trn_td_o .. trn_tsrc_rdy_n_o  muxed TRN tx outputs to the endpoint
//   trn_tdst_rdy_n_i         destination ready from the endpoint
//   trn_tbuf_av_i            buffer available from the endpoint
//   wdog_cnt_o               grants revoked by the watchdog (only with TRN_ARB_WDOG_EN)
//
// Configuration
//   TRN_ARB_WDOG_EN  when defined, a grantee that does not raise drv_ep within WDOG_CYC cycles
//                    loses the grant and wdog_cnt_o counts the event (saturating).

module trn_tx_arb #(
  parameter int unsigned N        = 2,
  parameter int unsigned WDOG_CYC = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    my_trn_o,
  input  logic [N-1:0]    drv_ep_i,
  input  logic [N*64-1:0] req_trn_td_i,
  input  logic [N*8-1:0]  req_trn_trem_n_i,
  input  logic [N-1:0]    req_trn_tsof_n_i,
  input  logic [N-1:0]    req_trn_teof_n_i,
  input  logic [N-1:0]    req_trn_tsrc_rdy_n_i,
  output logic [N-1:0]    req_trn_tdst_rdy_n_o,
  output logic [N*4-1:0]  req_trn_tbuf_av_o,
  output logic [63:0]     trn_td_o,
  output logic [7:0]      trn_trem_n_o,
  output logic            trn_tsof_n_o,
  output logic            trn_teof_n_o,
  output logic            trn_tsrc_rdy_n_o,
  input  logic            trn_tdst_rdy_n_i,
  input  logic [3:0]      trn_tbuf_av_i
`ifdef TRN_ARB_WDOG_EN
  ,
  output logic [15:0]     wdog_cnt_o
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StBusy,
    StRelease
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    my_trn_q, my_trn_d;
  logic [IW-1:0]   last_q, last_d;
  logic            in_pkt_q, in_pkt_d;

  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [IW-1:0]   scan_idx;
  logic            own_drv;
  logic            own_req;
  logic            beat_acc;
  logic            wdog_fire;

  // The grant register doubles as the owner decode: it is non-zero exactly in GRANT/BUSY.
  assign own_drv = |(drv_ep_i & my_trn_q);
  assign own_req = |(req_i & my_trn_q);

  assign my_trn_o          = my_trn_q;
  assign req_trn_tbuf_av_o = {N{trn_tbuf_av_i}};

  // Round-robin search starting one past the last grantee.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int unsigned j = 1; j <= N; j++) begin
      scan_idx = IW'((32'(last_q) + j) % N);
      if (!pick_vld && req_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick     = scan_idx;
      end
    end
  end

  // Output mux: idle values unless a requester owns the bus.
  always_comb begin
    trn_td_o             = '0;
    trn_trem_n_o         = 8'hFF;
    trn_tsof_n_o         = 1'b1;
    trn_teof_n_o         = 1'b1;
    trn_tsrc_rdy_n_o     = 1'b1;
    req_trn_tdst_rdy_n_o = '1;
    for (int i = 0; i < int'(N); i++) begin
      if (my_trn_q[i]) begin
        trn_td_o                = req_trn_td_i[64*i +: 64];
        trn_trem_n_o            = req_trn_trem_n_i[8*i +: 8];
        trn_tsof_n_o            = req_trn_tsof_n_i[i];
        trn_teof_n_o            = req_trn_teof_n_i[i];
        trn_tsrc_rdy_n_o        = req_trn_tsrc_rdy_n_i[i];
        req_trn_tdst_rdy_n_o[i] = trn_tdst_rdy_n_i;
      end
    end
  end

  // Idle outputs keep tsrc_rdy_n high, so no beat is ever seen without an owner.
  assign beat_acc = !trn_tsrc_rdy_n_o && !trn_tdst_rdy_n_i;

`ifdef TRN_ARB_WDOG_EN
  localparam int unsigned WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC + 1) : 1;

  logic [WW-1:0] wdog_age_q, wdog_age_d;
  logic [15:0]   wdog_cnt_q, wdog_cnt_d;

  // A dropped request takes priority over the timeout, so it is not counted as a violation.
  assign wdog_fire = (state_q == StGrant) && !own_drv && own_req &&
                     (wdog_age_q == WW'(WDOG_CYC - 1));

  always_comb begin
    wdog_age_d = wdog_age_q;
    wdog_cnt_d = wdog_cnt_q;
    if (state_q != StGrant) begin
      wdog_age_d = '0;
    end else if (!own_drv && !wdog_fire) begin
      wdog_age_d = wdog_age_q + 1'b1;
    end
    if (wdog_fire && (wdog_cnt_q != 16'hFFFF)) begin
      wdog_cnt_d = wdog_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_age_q <= '0;
      wdog_cnt_q <= '0;
    end else begin
      wdog_age_q <= wdog_age_d;
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

  assign wdog_cnt_o = wdog_cnt_q;
`else
  assign wdog_fire = 1'b0;
`endif

  // Arbitration also runs in RELEASE: the grant lands right after the single no-grant cycle.
  // last_q already points at the previous owner, so a revoked or finished grantee is searched last.
  always_comb begin
    state_d  = state_q;
    my_trn_d = my_trn_q;
    last_d   = last_q;
    case (state_q)
      StIdle, StRelease: begin
        state_d  = StIdle;
        my_trn_d = '0;
        if (pick_vld) begin
          state_d  = StGrant;
          my_trn_d = N'(1) << pick;
          last_d   = pick;
        end
      end
      StGrant: begin
        if (own_drv) begin
          state_d = StBusy;
        end else if (!own_req || wdog_fire) begin
          state_d  = StRelease;
          my_trn_d = '0;
        end
      end
      StBusy: begin
        // Owner keeps the bus while a TLP is open even if drv_ep drops early.
        if (!own_drv && !in_pkt_q) begin
          state_d  = StRelease;
          my_trn_d = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        my_trn_d = '0;
      end
    endcase
  end

  // TLP tracking on accepted beats; a single-beat TLP never opens a packet.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (beat_acc) begin
      if (!trn_teof_n_o) begin
        in_pkt_d = 1'b0;
      end else if (!trn_tsof_n_o) begin
        in_pkt_d = 1'b1;
      end
    end
    if ((state_d != StGrant) && (state_d != StBusy)) begin
      in_pkt_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      my_trn_q <= '0;
      last_q   <= IW'(N - 1);
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      my_trn_q <= my_trn_d;
      last_q   <= last_d;
      in_pkt_q <= in_pkt_d;
    end
  end

endmodule

// File: tb/tb_trn_tx_arb.sv
module tb_trn_tx_arb;

  localparam int unsigned N      = 3;
  localparam int unsigned WDOG   = 8;
  localparam int          CYCLES = 3000;
  localparam int          RST_AT = 1800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, drv, sof_n, eof_n, src_n, my_trn, dst_vec;
  logic [N*64-1:0] td;
  logic [N*8-1:0]  trem;
  logic [N*4-1:0]  tbuf_vec;
  logic [63:0]     o_td;
  logic [7:0]      o_trem;
  logic            o_sof, o_eof, o_src, tdst;
  logic [3:0]      tbuf;
`ifdef TRN_ARB_WDOG_EN
  logic [15:0]     wdog_cnt;
`endif

  trn_tx_arb #(.N(N), .WDOG_CYC(WDOG)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_i               (req),
    .my_trn_o            (my_trn),
    .drv_ep_i            (drv),
    .req_trn_td_i        (td),
    .req_trn_trem_n_i    (trem),
    .req_trn_tsof_n_i    (sof_n),
    .req_trn_teof_n_i    (eof_n),
    .req_trn_tsrc_rdy_n_i(src_n),
    .req_trn_tdst_rdy_n_o(dst_vec),
    .req_trn_tbuf_av_o   (tbuf_vec),
    .trn_td_o            (o_td),
    .trn_trem_n_o        (o_trem),
    .trn_tsof_n_o        (o_sof),
    .trn_teof_n_o        (o_eof),
    .trn_tsrc_rdy_n_o    (o_src),
    .trn_tdst_rdy_n_i    (tdst),
    .trn_tbuf_av_i       (tbuf)
`ifdef TRN_ARB_WDOG_EN
    ,
    .wdog_cnt_o          (wdog_cnt)
`endif
  );

  typedef struct {
    logic [N-1:0]   grant;
    logic [63:0]    td;
    logic [7:0]     trem;
    logic           sof, eof, src;
    logic [N-1:0]   dst;
    logic [N*4-1:0] tbuf;
    logic [15:0]    wd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: who owns the bus and what the owner has shown so far.
  int m_owner, m_last, m_age, m_wd;
  bit m_seen, m_pkt;

  // Requester behaviour: pending TLPs, the TLP in flight and the delay before driving.
  int pend[N], wait_c[N], left[N], idx[N];
  bit busy_r[N], early[N];

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] want);
    total++;
    if (act_v !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act_v, want, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = int'(N) - 1;
    m_seen  = 1'b0;
    m_age   = 0;
    m_pkt   = 1'b0;
    m_wd    = 0;
  endtask

  task automatic req_reset();
    for (int i = 0; i < int'(N); i++) begin
      pend[i] = 0; wait_c[i] = 0; left[i] = 0; idx[i] = 0; busy_r[i] = 1'b0; early[i] = 1'b0;
    end
  endtask

  task automatic drive_cycle(input int cyc);
    tdst = ((cyc % 97) < 5) ? 1'b1 : ($urandom_range(0, 3) == 0);
    tbuf = 4'($urandom);
    for (int i = 0; i < int'(N); i++) begin
      if (cyc >= 60 && (cyc >= 400 || i == 0) && pend[i] < 3 &&
          $urandom_range(0, (cyc < 400) ? 1 : 7) == 0) pend[i]++;
      // Non-owners present garbage that must never reach the endpoint.
      td[64*i +: 64]  = {$urandom, $urandom};
      trem[8*i +: 8]  = 8'($urandom);
      sof_n[i]        = 1'($urandom);
      eof_n[i]        = 1'($urandom);
      src_n[i]        = 1'($urandom);
      drv[i]          = 1'b0;
      if (m_owner == i) begin
        if (!busy_r[i]) begin
          if (wait_c[i] == 0) begin
            busy_r[i] = 1'b1;
            left[i]   = int'($urandom_range(1, 4));
            idx[i]    = 0;
            early[i]  = ($urandom_range(0, 2) == 0);
          end else begin
            wait_c[i]--;
            if ($urandom_range(0, 15) == 0) pend[i] = 0;
          end
        end
        if (busy_r[i]) begin
          src_n[i]       = ($urandom_range(0, 3) == 0);
          sof_n[i]       = (idx[i] != 0);
          eof_n[i]       = (left[i] != 1);
          trem[8*i +: 8] = (left[i] == 1 && $urandom_range(0, 1) == 0) ? 8'h0F : 8'h00;
          drv[i]         = !(early[i] && idx[i] > 0 && left[i] == 1);
        end else begin
          src_n[i] = 1'b1;
          sof_n[i] = 1'b1;
          eof_n[i] = 1'b1;
        end
      end
      req[i] = (pend[i] > 0) || busy_r[i];
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.grant = '0;
    e.td    = '0;
    e.trem  = 8'hFF;
    e.sof   = 1'b1;
    e.eof   = 1'b1;
    e.src   = 1'b1;
    e.dst   = '1;
    if (m_owner >= 0) begin
      e.grant[m_owner] = 1'b1;
      e.td             = td[64*m_owner +: 64];
      e.trem           = trem[8*m_owner +: 8];
      e.sof            = sof_n[m_owner];
      e.eof            = eof_n[m_owner];
      e.src            = src_n[m_owner];
      e.dst[m_owner]   = tdst;
    end
    e.tbuf = {N{tbuf}};
    e.wd   = 16'(m_wd);
    exp_q.push_back(e);
  endtask

  task automatic step_models();
    int own, c;
    bit acc, nxt_pkt;
    own = m_owner;
    acc = (own >= 0) && !src_n[own] && !tdst;
    if (rst) begin
      model_reset();
      req_reset();
      return;
    end
    if (acc && busy_r[own]) begin
      idx[own]++;
      left[own]--;
      if (left[own] == 0) begin
        busy_r[own] = 1'b0;
        if (pend[own] > 0) pend[own]--;
        wait_c[own] = ($urandom_range(0, 15) == 0) ? 12 : int'($urandom_range(0, 2));
      end
    end
    nxt_pkt = m_pkt;
    if (acc) begin
      if (!eof_n[own]) nxt_pkt = 1'b0;
      else if (!sof_n[own]) nxt_pkt = 1'b1;
    end
    if (own < 0) begin
      for (int k = 1; k <= int'(N); k++) begin
        c = (m_last + k) % int'(N);
        if (req[c] && m_owner < 0) begin
          m_owner = c;
          m_last  = c;
          m_seen  = 1'b0;
          m_age   = 0;
        end
      end
    end else if (!m_seen) begin
      if (drv[own]) m_seen = 1'b1;
      else if (!req[own]) m_owner = -1;
`ifdef TRN_ARB_WDOG_EN
      else if (m_age == int'(WDOG) - 1) begin
        m_owner = -1;
        if (m_wd < 65535) m_wd++;
      end else m_age++;
`endif
    end else if (!drv[own] && !m_pkt) begin
      m_owner = -1;
    end
    m_pkt = (m_owner >= 0) && nxt_pkt;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("my_trn", 64'(my_trn), 64'(e.grant));
        chk("trn_td", o_td, e.td);
        chk("trn_trem_n", 64'(o_trem), 64'(e.trem));
        chk("trn_tsof_n", 64'(o_sof), 64'(e.sof));
        chk("trn_teof_n", 64'(o_eof), 64'(e.eof));
        chk("trn_tsrc_rdy_n", 64'(o_src), 64'(e.src));
        chk("req_tdst_rdy_n", 64'(dst_vec), 64'(e.dst));
        chk("req_tbuf_av", 64'(tbuf_vec), 64'(e.tbuf));
`ifdef TRN_ARB_WDOG_EN
        chk("wdog_cnt", 64'(wdog_cnt), 64'(e.wd));
`endif
      end
    end
  end

  initial begin : stim
    int guard;
    rst   = 1'b1;
    req   = '0;
    drv   = '0;
    td    = '0;
    trem  = '1;
    sof_n = '1;
    eof_n = '1;
    src_n = '1;
    tdst  = 1'b1;
    tbuf  = '0;
    model_reset();
    req_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Two requesters competing right after reset: requester 0 must win first.
    pend[0] = 1;
    pend[1] = 1;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      rst = (cyc >= RST_AT && cyc < RST_AT + 2);
      drive_cycle(cyc);
      push_exp();
      step_models();
      @(posedge clk);
      #1;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
